// File: rtl/latch_strobe_tx.sv
// Transmit end of a level-sensitive latch interface: captures a word from a valid/ready
// source, then drives data_out/enable_out through a setup / pulse / hold sequence.
// Optional latch readback compare is enabled by defining LATCH_ECHO_CHECK_EN.
module latch_strobe_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] word_in,
`ifdef LATCH_ECHO_CHECK_EN
  input  logic [WIDTH-1:0] q_in,
  output logic             mismatch,
`endif
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             enable_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  // A zero-length pulse would never open the latch, so it is stretched to one cycle.
  localparam int unsigned PULSE_EFF = (PULSE_CYC < 1) ? 1 : PULSE_CYC;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_EFF - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign ready_out = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      // NOTE: data_out is reset as well, so the latch input is a known value
      // after reset and an interrupted transfer leaves no stale word behind.
      state      <= S_IDLE;
      cnt        <= '0;
      data_out   <= '0;
      enable_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (valid_in) begin
            data_out <= word_in;
            if (SETUP_CYC > 0) begin
              state <= S_SETUP;
              cnt   <= SETUP_LD;
            end else begin
              state      <= S_STROBE;
              cnt        <= PULSE_LD;
              enable_out <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (cnt == '0) begin
            state      <= S_STROBE;
            cnt        <= PULSE_LD;
            enable_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_STROBE: begin
          if (cnt == '0) begin
            enable_out <= 1'b0;
            if (HOLD_CYC > 0) begin
              state <= S_HOLD;
              cnt   <= HOLD_LD;
            end else begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          enable_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef LATCH_ECHO_CHECK_EN
  // The latch has been transparent for the whole pulse by its last cycle, so
  // its output must already equal the word being driven.
  logic last_strobe;
  assign last_strobe = (state == S_STROBE) && (cnt == '0);

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      mismatch <= 1'b0;
    end else if (last_strobe && (q_in != data_out)) begin
      mismatch <= 1'b1;
    end
  end
`else
  // Transmit path only: no readback port and no compare logic in this build.
`endif

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Randomized scoreboard bench for latch_strobe_tx: a default-timing instance and a
// zero-setup/zero-hold/one-cycle-pulse instance, each checked against a cycle-count model.
module tb_latch_strobe_tx;

  localparam int W   = 8;
  localparam int S_A = 1, P_A = 2, H_A = 1;
  localparam int S_Z = 0, P_Z = 1, H_Z = 0;

  logic         clock   = 1'b0;
  logic         reset_b = 1'b1;
  logic         valid_a = 1'b0, valid_z = 1'b0;
  logic [W-1:0] word_a  = '0,   word_z  = '0;
  logic         ready_a, en_a, busy_a, done_a;
  logic         ready_z, en_z, busy_z, done_z;
  logic [W-1:0] data_a, data_z;

`ifdef LATCH_ECHO_CHECK_EN
  logic [W-1:0] lq_a, lq_z, q_a, q_z;
  logic         mm_a, mm_z;
  logic         force_zero = 1'b0;

  // Behavioural model of the downstream latch.
  always_latch if (en_a) lq_a <= data_a;
  always_latch if (en_z) lq_z <= data_z;
  assign q_a = force_zero ? '0 : lq_a;
  assign q_z = lq_z;
`endif

  latch_strobe_tx #(.WIDTH(W), .SETUP_CYC(S_A), .PULSE_CYC(P_A), .HOLD_CYC(H_A), .CNT_W(4)) dut_a (
    .clock(clock), .reset_b(reset_b), .valid_in(valid_a), .word_in(word_a),
`ifdef LATCH_ECHO_CHECK_EN
    .q_in(q_a), .mismatch(mm_a),
`endif
    .ready_out(ready_a), .data_out(data_a), .enable_out(en_a), .busy(busy_a), .done(done_a)
  );

  latch_strobe_tx #(.WIDTH(W), .SETUP_CYC(S_Z), .PULSE_CYC(P_Z), .HOLD_CYC(H_Z), .CNT_W(4)) dut_z (
    .clock(clock), .reset_b(reset_b), .valid_in(valid_z), .word_in(word_z),
`ifdef LATCH_ECHO_CHECK_EN
    .q_in(q_z), .mismatch(mm_z),
`endif
    .ready_out(ready_z), .data_out(data_z), .enable_out(en_z), .busy(busy_z), .done(done_z)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer accepted at an edge keeps the block busy for
  // S+P+H cycles; enable is high during cycles S..S+P-1 of that window.
  int           bl_a, bl_z;
  logic [W-1:0] md_a, md_z;
  logic         mdone_a, mdone_z, acc_a, acc_z;
  logic [W-1:0] sq_a[$];
  logic [W-1:0] sq_z[$];

  always @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      bl_a <= 0; md_a <= '0; mdone_a <= 1'b0; acc_a <= 1'b0;
      sq_a.delete();
    end else begin
      mdone_a <= (bl_a == 1);
      acc_a   <= 1'b0;
      if (bl_a > 0) bl_a <= bl_a - 1;
      else if (valid_a) begin
        bl_a  <= S_A + P_A + H_A;
        md_a  <= word_a;
        acc_a <= 1'b1;
        sq_a.push_back(word_a);
      end
    end
  end

  always @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      bl_z <= 0; md_z <= '0; mdone_z <= 1'b0; acc_z <= 1'b0;
      sq_z.delete();
    end else begin
      mdone_z <= (bl_z == 1);
      acc_z   <= 1'b0;
      if (bl_z > 0) bl_z <= bl_z - 1;
      else if (valid_z) begin
        bl_z  <= S_Z + P_Z + H_Z;
        md_z  <= word_z;
        acc_z <= 1'b1;
        sq_z.push_back(word_z);
      end
    end
  end

  task automatic cycle_check(input string p, input int bl, input int s, input int pl, input int h,
                             input logic [W-1:0] md, input logic mdone,
                             input logic rdy, input logic bsy, input logic en,
                             input logic [W-1:0] dat, input logic dn);
    int   k;
    logic exp_en;
    k      = s + pl + h - bl;
    exp_en = (bl > 0) && (k >= s) && (k < s + pl);
    check({p, "_ready"},  rdy, bl == 0);
    check({p, "_busy"},   bsy, bl > 0);
    check({p, "_enable"}, en,  exp_en);
    check({p, "_data"},   dat, md);
    check({p, "_done"},   dn,  mdone);
  endtask

  // Monitor: per-cycle comparison plus scoreboard pop on every done pulse.
  logic [W-1:0] sw_a, sw_z;
  logic         prev_en_a = 1'b0, seen_pulse_a = 1'b0;
  int           low_run_a = 0;

  always @(negedge clock) begin
    if (reset_b) begin
      cycle_check("a", bl_a, S_A, P_A, H_A, md_a, mdone_a, ready_a, busy_a, en_a, data_a, done_a);
      cycle_check("z", bl_z, S_Z, P_Z, H_Z, md_z, mdone_z, ready_z, busy_z, en_z, data_z, done_z);

      if (en_a && !prev_en_a && seen_pulse_a)
        check("a_enable_gap_ok", low_run_a >= S_A + H_A, 1);
      if (en_a) begin
        sw_a         = data_a;
        seen_pulse_a = 1'b1;
        low_run_a    = 0;
      end else begin
        low_run_a++;
      end
      prev_en_a = en_a;
      if (en_z) sw_z = data_z;

      if (done_a) begin
        if (sq_a.size() == 0) check("a_done_without_word", 1, 0);
        else check("a_strobed_word", sw_a, sq_a.pop_front());
      end
      if (done_z) begin
        if (sq_z.size() == 0) check("z_done_without_word", 1, 0);
        else check("z_strobed_word", sw_z, sq_z.pop_front());
      end
    end else begin
      prev_en_a    = 1'b0;
      seen_pulse_a = 1'b0;
      low_run_a    = 0;
    end
  end

  // Drivers: called and returning at a negedge.
  task automatic send(input int d, input logic [W-1:0] w);
    int n = 0;
    if (d == 0) begin valid_a = 1'b1; word_a = w; end
    else        begin valid_z = 1'b1; word_z = w; end
    do begin
      @(negedge clock);
      n++;
    end while (!((d == 0) ? acc_a : acc_z) && n < 50);
    check((d == 0) ? "a_accept_in_time" : "z_accept_in_time", n < 50, 1);
    if (d == 0) valid_a = 1'b0;
    else        valid_z = 1'b0;
  endtask

  task automatic spurious_a(input logic [W-1:0] w);
    valid_a = 1'b1;
    word_a  = w;
    @(negedge clock);
    valid_a = 1'b0;
    word_a  = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_strobe_a();
    int n = 0;
    while (bl_a != P_A + H_A && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("a_reach_strobe_in_time", n < 20, 1);
  endtask

  task automatic pulse_reset();
    #2 reset_b = 1'b0;
    #1;
    check("rst_a_enable", en_a,   0);
    check("rst_a_data",   data_a, 0);
    check("rst_a_busy",   busy_a, 0);
    check("rst_a_done",   done_a, 0);
    check("rst_a_ready",  ready_a, 1);
    check("rst_z_enable", en_z,   0);
    check("rst_z_busy",   busy_z, 0);
    idle(2);
    reset_b = 1'b1;
    @(negedge clock);
    check("post_rst_a_ready", ready_a, 1);
  endtask

  initial begin
    #1 reset_b = 1'b0;
    #2;
    check("init_a_ready",  ready_a, 1);
    check("init_a_enable", en_a,    0);
    check("init_a_data",   data_a,  0);
    check("init_a_busy",   busy_a,  0);
    check("init_a_done",   done_a,  0);
    check("init_z_ready",  ready_z, 1);
    idle(2);
    reset_b = 1'b1;
    @(negedge clock);

    // Single transfer with default timing.
    send(0, 8'hA5);
    idle(6);

    // Back-to-back: valid stays high across both words.
    send(0, 8'h11);
    send(0, 8'h22);
    idle(6);

    // Valid pulsed during STROBE must be ignored.
    send(0, 8'h5A);
    wait_strobe_a();
    spurious_a(8'hFF);
    idle(6);

    // Asynchronous reset while enable_out is high.
    send(0, 8'hC3);
    wait_strobe_a();
    check("a_enable_before_reset", en_a, 1);
    pulse_reset();
    idle(3);

    // Zero-length setup/hold with a single-cycle pulse.
    send(1, 8'h81);
    idle(3);
    send(1, 8'h42);
    send(1, 8'h24);
    idle(3);

    // Randomized traffic on both instances.
    for (int i = 0; i < 25; i++) begin
      send(0, W'($urandom));
      if ($urandom_range(0, 2) == 0 && bl_a > 1) spurious_a(W'($urandom));
      idle($urandom_range(0, 3));
      send(1, W'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(8);
    check("a_queue_drained", sq_a.size(), 0);
    check("z_queue_drained", sq_z.size(), 0);

`ifdef LATCH_ECHO_CHECK_EN
    check("a_mismatch_clean", mm_a, 0);
    check("z_mismatch_clean", mm_z, 0);
    force_zero = 1'b1;
    send(0, 8'h3C);
    idle(5);
    force_zero = 1'b0;
    check("a_mismatch_set", mm_a, 1);
    send(0, W'($urandom));
    idle(5);
    check("a_mismatch_sticky", mm_a, 1);
    check("z_mismatch_unaffected", mm_z, 0);
    @(negedge clock);
    pulse_reset();
    check("a_mismatch_cleared", mm_a, 0);
`endif

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
